// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the data memory arbiter
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic port_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin pointer and winner selection
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output port_idx_t  winner,
  output logic       any
);

  // prio names the port that wins a tie; it flips away from each accepted winner
  port_idx_t prio;

  always_comb begin
    winner = prio;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

  assign any = |req;

  always_ff @(posedge clk) begin
    if (rst) prio <= 1'b0;
    else if (accept) prio <= ~winner;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter onto a single shared-bus data memory
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int SIM_MEM_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [31:0]           p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [31:0]           p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [31:0]           p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [31:0]           p1_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  inout  tri   [31:0]           mem_bus_io
);

  state_t                  state;
  port_idx_t               win_q;
  logic                    we_q;
  logic [31:0]             wdata_q;
  port_idx_t               winner;
  logic                    any_req;
  logic                    accept;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [31:0]             sel_wdata;

  assign accept = (state == IDLE) && any_req;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({p1_req_i, p0_req_i}),
    .accept (accept),
    .winner (winner),
    .any    (any_req)
  );

  assign sel_we    = winner ? p1_we_i    : p0_we_i;
  assign sel_addr  = winner ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = winner ? p1_wdata_i : p0_wdata_i;

  // mem_we_o is high exactly in a write ACCESS cycle, so it doubles as the bus drive enable
  assign mem_bus_io = mem_we_o ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      p0_gnt_o    <= 1'b0;
      p1_gnt_o    <= 1'b0;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
      p0_rdata_o  <= '0;
      p1_rdata_o  <= '0;
      mem_addr_o  <= '0;
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
    end else begin
      p0_gnt_o    <= 1'b0;
      p1_gnt_o    <= 1'b0;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            win_q      <= winner;
            we_q       <= sel_we;
            wdata_q    <= sel_wdata;
            p0_gnt_o   <= !winner;
            p1_gnt_o   <= winner;
            mem_addr_o <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_we_o   <= sel_we;
            mem_re_o   <= !sel_we;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (win_q) begin
            p1_rvalid_o <= 1'b1;
            p1_rdata_o  <= we_q ? 32'h0 : mem_bus_io;
          end else begin
            p0_rvalid_o <= 1'b1;
            p0_rdata_o  <= we_q ? 32'h0 : mem_bus_io;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_re_o && mem_we_o));
      assert (!(p0_gnt_o && p1_gnt_o));
      assert (int'(mem_addr_o) < 4 * SIM_MEM_SIZE);
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

  localparam int AW    = 10;
  localparam int WORDS = 256;

  typedef struct {
    int          port;
    logic        we;
    logic [AW-1:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr [2];
  logic [31:0]   wdata [2];
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [31:0]   rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  tri   [31:0]   mem_bus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .SIM_MEM_SIZE(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_req_i    (req[0]),
    .p0_we_i     (we[0]),
    .p0_addr_i   (addr[0]),
    .p0_wdata_i  (wdata[0]),
    .p0_gnt_o    (gnt[0]),
    .p0_rvalid_o (rvalid[0]),
    .p0_rdata_o  (rdata0),
    .p1_req_i    (req[1]),
    .p1_we_i     (we[1]),
    .p1_addr_i   (addr[1]),
    .p1_wdata_i  (wdata[1]),
    .p1_gnt_o    (gnt[1]),
    .p1_rvalid_o (rvalid[1]),
    .p1_rdata_o  (rdata1),
    .mem_addr_o  (mem_addr),
    .mem_re_o    (mem_re),
    .mem_we_o    (mem_we),
    .mem_bus_io  (mem_bus)
  );

  // Behavioural memory on the shared bus
  logic [31:0] init_mem [WORDS];
  logic [31:0] mem [WORDS];
  assign mem_bus = mem_re ? mem[mem_addr[AW-1:2]] : 'z;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_mem[i];
    end else if (mem_we) begin
      mem[mem_addr[AW-1:2]] <= mem_bus;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction per three cycles, tie goes to the port not served last
  logic [31:0] ref_mem [WORDS];
  txn_t gq[$];
  txn_t rq[$];
  int busy = 0;
  int last = 1;
  logic [31:0] hold [2];
  int m_w;
  txn_t m_t;

  always @(posedge clk) begin
    if (rst) begin
      busy = 0;
      last = 1;
      gq.delete();
      rq.delete();
      hold[0] = 32'h0;
      hold[1] = 32'h0;
    end else if (busy > 0) begin
      busy--;
    end else if (req != 2'b00) begin
      m_w = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
      last = m_w;
      m_t.port  = m_w;
      m_t.we    = we[m_w];
      m_t.waddr = addr[m_w] - AW'(addr[m_w] % 4);
      m_t.wdata = wdata[m_w];
      if (m_t.we) begin
        ref_mem[addr[m_w] / 4] = m_t.wdata;
        m_t.rdata = 32'h0;
      end else begin
        m_t.rdata = ref_mem[addr[m_w] / 4];
      end
      gq.push_back(m_t);
      rq.push_back(m_t);
      busy = 2;
    end
  end

  // Monitor
  bit mon_en = 0;
  int cycle = 0;
  int re_cycles = 0;
  int gnt_log_port[$];
  int gnt_log_cyc[$];
  logic [AW-1:0] last_gnt_addr;
  txn_t c_t;

  always @(posedge clk) begin
    #3;
    cycle++;
    if (mon_en) begin
      if (mem_re) re_cycles++;
      check("double_gnt", 32'(gnt == 2'b11), 32'h0);
      check("re_and_we", 32'(mem_re && mem_we), 32'h0);
      check("gnt_timing", 32'(|gnt), 32'(busy == 2));
      check("rvalid_timing", 32'(|rvalid), 32'(busy == 1));
      if ((|gnt) && gq.size() > 0) begin
        c_t = gq.pop_front();
        gnt_log_port.push_back(gnt[1] ? 1 : 0);
        gnt_log_cyc.push_back(cycle);
        last_gnt_addr = mem_addr;
        check("gnt_port", 32'(gnt[c_t.port]), 32'h1);
        check("mem_addr", 32'(mem_addr), 32'(c_t.waddr));
        check("mem_we", 32'(mem_we), 32'(c_t.we));
        check("mem_re", 32'(mem_re), 32'(!c_t.we));
        if (c_t.we) check("bus_wdata", mem_bus, c_t.wdata);
      end else begin
        check("idle_mem_re", 32'(mem_re), 32'h0);
        check("idle_mem_we", 32'(mem_we), 32'h0);
        check("idle_mem_addr", 32'(mem_addr), 32'h0);
      end
      if ((|rvalid) && rq.size() > 0) begin
        c_t = rq.pop_front();
        check("rvalid_port", 32'(rvalid[c_t.port]), 32'h1);
        hold[c_t.port] = c_t.rdata;
      end
      check("p0_rdata", rdata0, hold[0]);
      check("p1_rdata", rdata1, hold[1]);
    end
  end

  task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                     input bit may_drop, output logic [31:0] rd);
    int n;
    rd = 32'h0;
    we[p] = w;
    addr[p] = a;
    wdata[p] = d;
    req[p] = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gnt[p]) break;
      if (may_drop && $urandom_range(0, 9) == 0) begin
        req[p] = 1'b0;
        return;
      end
    end
    req[p] = 1'b0;
    if (n == 100) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout port=%0d actual=no_gnt required=gnt", p);
      return;
    end
    @(negedge clk);
    check("rvalid_latency", 32'(rvalid[p]), 32'h1);
    rd = p ? rdata1 : rdata0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int rc0;
    int n;
    rst = 1'b1;
    load = 1'b1;
    req = 2'b00;
    we = 2'b00;
    addr[0] = '0;
    addr[1] = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    for (int i = 0; i < WORDS; i++) init_mem[i] = $urandom;
    init_mem[4] = 32'hDEADBEEF;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_mem[i];
    repeat (3) @(negedge clk);
    load = 1'b0;
    mon_en = 1;
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_rdata0", rdata0, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    rc0 = re_cycles;
    txn(0, 1'b0, 10'h010, 32'h0, 1'b0, rd);
    check("p0_read_deadbeef", rd, 32'hDEADBEEF);
    check("re_one_cycle", 32'(re_cycles - rc0), 32'h1);

    txn(1, 1'b1, 10'h020, 32'h12345678, 1'b0, rd);
    check("p1_write_rdata_zero", rd, 32'h0);
    txn(0, 1'b0, 10'h020, 32'h0, 1'b0, rd);
    check("p0_readback", rd, 32'h12345678);

    txn(1, 1'b0, 10'h013, 32'h0, 1'b0, rd);
    check("misaligned_addr", 32'(last_gnt_addr), 32'h010);
    check("misaligned_rdata", rd, 32'hDEADBEEF);

    gnt_log_port.delete();
    gnt_log_cyc.delete();
    fork
      begin
        logic [31:0] r0;
        txn(0, 1'b0, 10'h020, 32'h0, 1'b0, r0);
        txn(0, 1'b0, 10'h024, 32'h0, 1'b0, r0);
      end
      begin
        logic [31:0] r1;
        txn(1, 1'b0, 10'h010, 32'h0, 1'b0, r1);
        txn(1, 1'b0, 10'h014, 32'h0, 1'b0, r1);
      end
    join
    check("rr_count", 32'(gnt_log_port.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log_port.size(); i++)
      check("rr_order", 32'(gnt_log_port[i]), 32'(i % 2));
    for (int i = 1; i < 4 && i < gnt_log_cyc.size(); i++)
      check("rr_spacing", 32'(gnt_log_cyc[i] - gnt_log_cyc[i-1]), 32'd3);

    we[0] = 1'b1;
    addr[0] = 10'h030;
    wdata[0] = 32'hCAFEF00D;
    req[0] = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt[0]) break;
    end
    check("rst_test_gnt", 32'(gnt[0]), 32'h1);
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_rvalid", 32'(rvalid), 32'h0);
    check("rst_abort_we", 32'(mem_we), 32'h0);
    check("rst_abort_addr", 32'(mem_addr), 32'h0);
    check("rst_abort_rdata1", rdata1, 32'h0);
    @(negedge clk);
    check("rst_abort_rvalid_late", 32'(rvalid), 32'h0);
    txn(0, 1'b0, 10'h010, 32'h0, 1'b0, rd);
    check("after_rst_read", rd, 32'hDEADBEEF);

    fork
      begin
        logic [31:0] ra;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          txn(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom, 1'b1, ra);
        end
      end
      begin
        logic [31:0] rb;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          txn(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom, 1'b1, rb);
        end
      end
    join
    repeat (5) @(negedge clk);
    check("gq_drained", 32'(gq.size()), 32'h0);
    check("rq_drained", 32'(rq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
